// File: rtl/csa_pkg.sv
// Shared definitions for the CSA key controller: widths, FSM encoding and
// the bit permutation used between key schedule rounds.
package csa_pkg;

    localparam int CK_W   = 64;
    localparam int KK_W   = 448;
    localparam int ROUNDS = KK_W / CK_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Bit permutation applied between rounds: bit i moves to (17*i + 5) mod 64.
    // 17 is odd, so the mapping is a bijection on 0..63.
    function automatic logic [CK_W-1:0] key_perm(input logic [CK_W-1:0] k);
        logic [CK_W-1:0] p;
        p = '0;
        for (int i = 0; i < CK_W; i++) begin
            p[(i * 17 + 5) % CK_W] = k[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/key_schedule.sv
// Combinational key expansion: 64-bit control word to seven 64-bit round keys.
// Round 6 (bits [447:384]) is derived from the control word directly; each
// lower round applies one more key_perm. Every round key is XORed with its
// round index replicated into all eight bytes.
module key_schedule
    import csa_pkg::*;
(
    input  logic [CK_W-1:0] i_ck,
    output logic [KK_W-1:0] o_kk
);

    logic [CK_W-1:0] k;

    // Unrolled chain of permutations, highest round first.
    always_comb begin
        k    = i_ck;
        o_kk = '0;
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            o_kk[r*CK_W +: CK_W] = k ^ {8{8'(r)}};
            k = key_perm(k);
        end
    end

endmodule

// File: rtl/csa_key_ctrl.sv
// Sequencing controller around key_schedule. A control word accepted over
// valid/ready is held in ck_reg for SCHED_LAT cycles so the combinational
// schedule settles, then the full 448-bit result is committed in one edge to
// the even or odd bank. The bank chosen by i_sel_odd is registered onto o_kk.
//
// Handshake: a word transfers on a rising edge where i_ck_valid and o_ck_ready
// are both 1; o_ck_ready depends only on the FSM state and i_clear, never on
// i_ck_valid, and i_ck / i_ck_odd are sampled only on that edge.
// SCHED_LAT must lie in 1..15 (cnt is 4 bits wide).
module csa_key_ctrl
    import csa_pkg::*;
#(
    parameter int SCHED_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ck_valid,
    output logic             o_ck_ready,
    input  logic [CK_W-1:0]  i_ck,
    input  logic             i_ck_odd,
    input  logic             i_clear,
    input  logic             i_sel_odd,
    output logic [KK_W-1:0]  o_kk,
    output logic             o_kk_valid,
    output logic             o_busy
);

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;
    logic [CK_W-1:0] ck_reg;
    logic            par_reg;
    logic [KK_W-1:0] sched_kk;
    logic [KK_W-1:0] bank_even;
    logic [KK_W-1:0] bank_odd;
    logic [1:0]      bank_valid;
    logic [KK_W-1:0] kk_reg;
    logic            kk_valid_reg;
    logic            accept;
    logic            commit;

    key_schedule u_key_schedule (
        .i_ck (ck_reg),
        .o_kk (sched_kk)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; i_clear overrides everything and returns to IDLE.
    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (i_ck_valid) state_next = ST_WAIT;
                ST_WAIT:   if (cnt == 4'd0) state_next = ST_COMMIT;
                ST_COMMIT: state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: ready/busy plus the accept and commit strobes.
    always_comb begin
        o_ck_ready = 1'b0;
        o_busy     = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ck_ready = ~i_clear;
                accept     = i_ck_valid & ~i_clear;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
            end
            ST_COMMIT: begin
                o_busy = 1'b1;
                commit = ~i_clear;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Capture the control word on the handshake edge and run the settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_reg  <= '0;
            par_reg <= 1'b0;
            cnt     <= 4'd0;
        end else if (accept) begin
            ck_reg  <= i_ck;
            par_reg <= i_ck_odd;
            cnt     <= 4'(SCHED_LAT - 1);
        end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Key banks: the whole 448-bit key lands on the single commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_even <= '0;
            bank_odd  <= '0;
        end else if (commit) begin
            if (par_reg) begin
                bank_odd <= sched_kk;
            end else begin
                bank_even <= sched_kk;
            end
        end
    end

    // Bank valid bits; a clear wipes both but leaves the bank data alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_valid <= 2'b00;
        end else if (i_clear) begin
            bank_valid <= 2'b00;
        end else if (commit) begin
            bank_valid[par_reg] <= 1'b1;
        end
    end

    // Registered output mux toward the descrambler core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kk_reg       <= '0;
            kk_valid_reg <= 1'b0;
        end else begin
            kk_reg       <= i_sel_odd ? bank_odd : bank_even;
            kk_valid_reg <= bank_valid[i_sel_odd];
        end
    end

    assign o_kk       = kk_reg;
    assign o_kk_valid = kk_valid_reg;

endmodule

// File: tb/tb_csa_key_ctrl.sv
// Self-checking bench for csa_key_ctrl with a behavioural bank model.
module tb_csa_key_ctrl;

    localparam int SL = 2;
    localparam int P  = SL + 2;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         i_ck_valid = 1'b0;
    logic [63:0]  i_ck       = '0;
    logic         i_ck_odd   = 1'b0;
    logic         i_clear    = 1'b0;
    logic         i_sel_odd  = 1'b0;
    logic         o_ck_ready;
    logic [447:0] o_kk;
    logic         o_kk_valid;
    logic         o_busy;

    int checks   = 0;
    int failures = 0;

    logic [447:0] bank_m  [2];
    logic         valid_m [2];
    logic [64:0]  exp_q[$];

    csa_key_ctrl #(.SCHED_LAT(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ck_valid (i_ck_valid),
        .o_ck_ready (o_ck_ready),
        .i_ck       (i_ck),
        .i_ck_odd   (i_ck_odd),
        .i_clear    (i_clear),
        .i_sel_odd  (i_sel_odd),
        .o_kk       (o_kk),
        .o_kk_valid (o_kk_valid),
        .o_busy     (o_busy)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference key schedule: follow each control word bit through the
    // rounds by position, XORing in the round index bit for that byte lane.
    function automatic logic [447:0] model_ks(input logic [63:0] ck);
        logic [447:0] kk;
        int p;
        kk = '0;
        for (int i = 0; i < 64; i++) begin
            p = i;
            for (int r = 6; r >= 0; r--) begin
                kk[r*64 + p] = ck[i] ^ 1'((r >> (p % 8)) & 1);
                p = (p * 17 + 5) % 64;
            end
        end
        return kk;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Bounded wait at a falling edge until the controller is ready.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (o_ck_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_ck_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b exp=1", tag, o_ck_ready);
        end
    endtask

    // One load with per-cycle checks of outputs from handshake to visibility.
    task automatic load_watch(input logic [63:0] ck, input logic odd, input string tag);
        wait_ready(tag);
        i_ck_valid = 1'b1;
        i_ck       = ck;
        i_ck_odd   = odd;
        @(posedge clk);
        @(negedge clk);
        i_ck_valid = 1'b0;
        i_ck       = rand64();
        i_ck_odd   = 1'($urandom_range(0, 1));
        for (int k = 0; k <= SL + 2; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (o_kk !== bank_m[i_sel_odd]) begin
                failures++;
                $display("FAIL %s kk edge+%0d got=%h exp=%h", tag, k, o_kk, bank_m[i_sel_odd]);
            end
            checks++;
            if (o_kk_valid !== valid_m[i_sel_odd]) begin
                failures++;
                $display("FAIL %s kk_valid edge+%0d got=%b exp=%b", tag, k, o_kk_valid, valid_m[i_sel_odd]);
            end
            checks++;
            if (o_busy !== (k <= SL)) begin
                failures++;
                $display("FAIL %s busy edge+%0d got=%b exp=%b", tag, k, o_busy, (k <= SL));
            end
            checks++;
            if (o_ck_ready !== (k > SL)) begin
                failures++;
                $display("FAIL %s ready edge+%0d got=%b exp=%b", tag, k, o_ck_ready, (k > SL));
            end
            if (k == SL + 1) begin
                bank_m[odd]  = model_ks(ck);
                valid_m[odd] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        bank_m[0] = '0; bank_m[1] = '0;
        valid_m[0] = 1'b0; valid_m[1] = 1'b0;
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (o_kk !== '0) begin
                failures++;
                $display("FAIL reset kk pass%0d got=%h exp=0", pass, o_kk);
            end
            checks++;
            if (o_kk_valid !== 1'b0 || o_busy !== 1'b0 || o_ck_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset flags pass%0d got=v%b b%b r%b exp=v0 b0 r1", pass, o_kk_valid, o_busy, o_ck_ready);
            end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_load_even();
        i_sel_odd = 1'b0;
        load_watch(64'h0123456789ABCDEF, 1'b0, "s1_even");
        checks++;
        if (o_kk !== model_ks(64'h0123456789ABCDEF) || o_kk_valid !== 1'b1) begin
            failures++;
            $display("FAIL s1_direct got=%h v=%b exp=%h v=1", o_kk, o_kk_valid, model_ks(64'h0123456789ABCDEF));
        end
    endtask

    task automatic test_load_odd_then_select();
        load_watch(64'hFFFFFFFFFFFFFFFF, 1'b1, "s2_odd");
        i_sel_odd = 1'b1;
        checks++;
        if (o_kk !== bank_m[0]) begin
            failures++;
            $display("FAIL s2_before_sel got=%h exp=%h", o_kk, bank_m[0]);
        end
        @(negedge clk);
        checks++;
        if (o_kk !== model_ks(64'hFFFFFFFFFFFFFFFF) || o_kk_valid !== 1'b1) begin
            failures++;
            $display("FAIL s2_after_sel got=%h v=%b exp=%h v=1", o_kk, o_kk_valid, model_ks(64'hFFFFFFFFFFFFFFFF));
        end
    endtask

    task automatic test_reload_selected();
        i_sel_odd = 1'b0;
        @(negedge clk);
        load_watch(64'h0, 1'b0, "s3_reload");
        checks++;
        if (o_kk !== model_ks(64'h0) || o_kk_valid !== 1'b1) begin
            failures++;
            $display("FAIL s3_direct got=%h v=%b exp=%h v=1", o_kk, o_kk_valid, model_ks(64'h0));
        end
    endtask

    task automatic test_clear();
        i_sel_odd = 1'b1;
        @(negedge clk);
        // Clear during WAIT of an odd-bank load.
        wait_ready("s4_wait");
        i_ck_valid = 1'b1; i_ck = rand64(); i_ck_odd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ck_valid = 1'b0;
        i_clear    = 1'b1;
        #1;
        checks++;
        if (o_ck_ready !== 1'b0) begin
            failures++;
            $display("FAIL s4_ready_in_clear got=%b exp=0", o_ck_ready);
        end
        @(posedge clk);
        valid_m[0] = 1'b0; valid_m[1] = 1'b0;
        @(negedge clk);
        i_clear = 1'b0;
        #1;
        checks++;
        if (o_ck_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL s4_after_clear got=r%b b%b exp=r1 b0", o_ck_ready, o_busy);
        end
        for (int k = 0; k < SL + 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_kk !== bank_m[1] || o_kk_valid !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL s4_odd_hold cyc%0d got=%h v=%b b=%b exp=%h v=0 b=0", k, o_kk, o_kk_valid, o_busy, bank_m[1]);
            end
        end
        i_sel_odd = 1'b0;
        @(negedge clk);
        checks++;
        if (o_kk !== bank_m[0] || o_kk_valid !== 1'b0) begin
            failures++;
            $display("FAIL s4_even_read got=%h v=%b exp=%h v=0", o_kk, o_kk_valid, bank_m[0]);
        end
        // Clear in the COMMIT cycle of an even-bank load.
        wait_ready("s4_commit");
        i_ck_valid = 1'b1; i_ck = rand64(); i_ck_odd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_ck_valid = 1'b0;
        repeat (SL) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL s4_commit_busy got=%b exp=1", o_busy);
        end
        i_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_clear = 1'b0;
        for (int k = 0; k < SL + 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_kk !== bank_m[0] || o_kk_valid !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL s4_no_commit cyc%0d got=%h v=%b b=%b exp=%h v=0 b=0", k, o_kk, o_kk_valid, o_busy, bank_m[0]);
            end
        end
        // A handshake offered together with i_clear is refused.
        i_clear = 1'b1; i_ck_valid = 1'b1; i_ck = rand64();
        #1;
        checks++;
        if (o_ck_ready !== 1'b0) begin
            failures++;
            $display("FAIL s4_idle_clear_ready got=%b exp=0", o_ck_ready);
        end
        @(posedge clk);
        @(negedge clk);
        i_clear = 1'b0; i_ck_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL s4_refused_busy got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_async_reset();
        i_sel_odd = 1'b0;
        load_watch(rand64(), 1'b0, "s5_pre");
        wait_ready("s5_mid");
        i_ck_valid = 1'b1; i_ck = rand64(); i_ck_odd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ck_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_kk !== '0 || o_kk_valid !== 1'b0) begin
            failures++;
            $display("FAIL s5_async_kk got=%h v=%b exp=0 v=0", o_kk, o_kk_valid);
        end
        checks++;
        if (o_busy !== 1'b0 || o_ck_ready !== 1'b1) begin
            failures++;
            $display("FAIL s5_async_flags got=b%b r%b exp=b0 r1", o_busy, o_ck_ready);
        end
        bank_m[0] = '0; bank_m[1] = '0;
        valid_m[0] = 1'b0; valid_m[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_watch(rand64(), 1'b0, "s5_post");
    endtask

    task automatic test_back_to_back();
        logic [447:0] exp_kk;
        logic         exp_v;
        logic [64:0]  w;
        exp_kk = '0;
        exp_v  = 1'b0;
        wait_ready("s6");
        for (int k = 0; k < 6 * P; k++) begin
            if (k > 0) begin
                checks++;
                if (o_kk !== exp_kk || o_kk_valid !== exp_v) begin
                    failures++;
                    $display("FAIL s6_kk edge%0d got=%h v=%b exp=%h v=%b", k - 1, o_kk, o_kk_valid, exp_kk, exp_v);
                end
            end
            checks++;
            if (o_ck_ready !== (k % P == 0)) begin
                failures++;
                $display("FAIL s6_ready edge%0d got=%b exp=%b", k, o_ck_ready, (k % P == 0));
            end
            i_ck_valid = 1'b1;
            i_ck       = rand64();
            i_ck_odd   = 1'($urandom_range(0, 1));
            i_sel_odd  = 1'($urandom_range(0, 1));
            exp_kk = bank_m[i_sel_odd];
            exp_v  = valid_m[i_sel_odd];
            if (k % P == 0) exp_q.push_back({i_ck_odd, i_ck});
            if (k % P == SL + 1) begin
                w = exp_q.pop_front();
                bank_m[w[64]]  = model_ks(w[63:0]);
                valid_m[w[64]] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        i_ck_valid = 1'b0;
        checks++;
        if (o_kk !== exp_kk || o_kk_valid !== exp_v) begin
            failures++;
            $display("FAIL s6_kk_last got=%h v=%b exp=%h v=%b", o_kk, o_kk_valid, exp_kk, exp_v);
        end
        // Both banks now hold the last words committed to each.
        for (int s = 0; s < 2; s++) begin
            i_sel_odd = 1'(s);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (o_kk !== bank_m[s] || o_kk_valid !== valid_m[s]) begin
                failures++;
                $display("FAIL s6_bank%0d got=%h v=%b exp=%h v=%b", s, o_kk, o_kk_valid, bank_m[s], valid_m[s]);
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_load_even();
        test_load_odd_then_select();
        test_reload_selected();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
